// File: rtl/sc_pkg.sv
// ---------------------------------------------------------------------------
// sc_pkg
// Shared definitions for the stochastic-computing blocks.
//   seq_state_t : state encoding of the neuron sequencer
//   LFSR_W      : width of the pseudo-random generator
//   LFSR_TAPS   : feedback mask for x^16 + x^14 + x^13 + x^11 + 1
//   lfsr_next() : one step of the left-shifting Fibonacci LFSR
// ---------------------------------------------------------------------------
package sc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } seq_state_t;

  localparam int LFSR_W = 16;

  // Tap positions 16,14,13,11 map to bits 15,13,12,10.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  // Shift left, XOR of the tapped bits enters at bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sc_lfsr.sv
// ---------------------------------------------------------------------------
// sc_lfsr
// 16-bit Fibonacci LFSR used for select streams and by the SNG blocks.
// Ports:
//   clk   in  1       clock, rising edge
//   reset in  1       synchronous, active-high; loads SEED
//   load  in  1       load 'seed' (wins over step)
//   seed  in  LFSR_W  value loaded on 'load'
//   step  in  1       advance one LFSR step
//   q     out LFSR_W  current LFSR state
// ---------------------------------------------------------------------------
module sc_lfsr
  import sc_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              step,
  output logic [LFSR_W-1:0] q
);

  // State register: a reload always restarts the sequence from the seed so
  // that repeated runs produce the same stream; otherwise advance on request.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= SEED;
    end else if (load) begin
      q <= seed;
    end else if (step) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/sc_neuron_seq.sv
// ---------------------------------------------------------------------------
// sc_neuron_seq
// Sequencer for one stochastic-computing MUX neuron. A run clears the
// neuron, drives 'len' pseudo-random select values, counts the '1's coming
// back on the neuron output (aligned for the neuron latency LAT), and
// reports the count with a one-cycle done pulse.
// Ports:
//   clk       in  1      clock, rising edge
//   reset     in  1      synchronous, active-high
//   start     in  1      request a run (accepted only when ready=1)
//   len       in  LEN_W  stream length, sampled with an accepted start
//   abort     in  1      cancel a run in progress, no done pulse
//   nrn_dout  in  1      neuron output bitstream
//   ready     out 1      high in IDLE
//   nrn_reset out 1      synchronous clear to the neuron / tanh state
//   sel       out K      neuron select
//   stream_en out 1      high while sel carries a valid stream bit
//   done      out 1      one-cycle pulse, result valid in the same cycle
//   result    out LEN_W  count of sampled '1's, held until next start
// ---------------------------------------------------------------------------
module sc_neuron_seq
  import sc_pkg::*;
#(
  parameter int                K     = 3,
  parameter int                LEN_W = 8,
  parameter int                LAT   = 1,
  parameter logic [LFSR_W-1:0] SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic             nrn_dout,
  output logic             ready,
  output logic             nrn_reset,
  output logic [K-1:0]     sel,
  output logic             stream_en,
  output logic             done,
  output logic [LEN_W-1:0] result
);

  localparam logic [LEN_W-1:0] ONE        = LEN_W'(1);
  localparam logic [2:0]       DRAIN_INIT = (LAT > 0) ? 3'(LAT - 1) : 3'd0;

  seq_state_t        state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt;
  logic [2:0]        dcnt;
  logic [LFSR_W-1:0] lfsr_q;
  logic              lfsr_load;
  logic              lfsr_step;
  logic              abort_hit;
  logic              samp_en;
  logic              lfsr_hi_unused;

  // Only the low K LFSR bits leave this block; the rest just feed the
  // feedback network inside sc_lfsr.
  assign lfsr_hi_unused = ^lfsr_q[LFSR_W-1:K];

  // Abort only matters while a run is active; in IDLE and DONE it is ignored.
  assign abort_hit = abort && (state == S_CLR || state == S_RUN || state == S_DRAIN);

  // The LFSR restarts from the seed on every accepted start. It steps on the
  // edge entering RUN and on every RUN cycle, so the value captured into sel
  // at each edge is the next element of the sequence.
  assign lfsr_load = (state == S_IDLE) && start;
  assign lfsr_step = ((state == S_CLR) && (len_q != '0)) || (state == S_RUN);

  sc_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load),
    .seed  (SEED),
    .step  (lfsr_step),
    .q     (lfsr_q)
  );

  // The neuron answers LAT cycles after a select is presented, so stream_en
  // is delayed by LAT to decide which output bits belong to the stream.
  // Clearing the line on abort keeps a cancelled run from counting late bits.
  generate
    if (LAT == 0) begin : g_no_delay
      assign samp_en = stream_en;
    end else begin : g_delay
      logic [LAT-1:0] dly;

      always_ff @(posedge clk) begin
        if (reset || abort_hit) begin
          dly <= '0;
        end else begin
          dly <= (dly << 1) | LAT'(stream_en);
        end
      end

      assign samp_en = dly[LAT-1];
    end
  endgenerate

  // Main sequencer. Every output is registered and set on the edge that
  // enters the state it belongs to. The result counter runs in all states
  // because samp_en already restricts it to the run's output bits; the
  // clear on an accepted start is written after the increment so it wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ready     <= 1'b1;
      nrn_reset <= 1'b1;
      sel       <= '0;
      stream_en <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      len_q     <= '0;
      cnt       <= '0;
      dcnt      <= 3'd0;
    end else begin
      done <= 1'b0;
      if (samp_en && nrn_dout) begin
        result <= result + ONE;
      end
      if (abort_hit) begin
        state     <= S_IDLE;
        ready     <= 1'b1;
        nrn_reset <= 1'b1;
        sel       <= '0;
        stream_en <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              len_q  <= len;
              result <= '0;
              ready  <= 1'b0;
              state  <= S_CLR;
            end
          end
          S_CLR: begin
            nrn_reset <= 1'b0;
            if (len_q != '0) begin
              state     <= S_RUN;
              cnt       <= len_q - ONE;
              stream_en <= 1'b1;
              sel       <= lfsr_q[K-1:0];
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
          S_RUN: begin
            if (cnt != '0) begin
              cnt <= cnt - ONE;
              sel <= lfsr_q[K-1:0];
            end else begin
              stream_en <= 1'b0;
              sel       <= '0;
              if (LAT == 0) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state <= S_DRAIN;
                dcnt  <= DRAIN_INIT;
              end
            end
          end
          S_DRAIN: begin
            if (dcnt == 3'd0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              dcnt <= dcnt - 3'd1;
            end
          end
          S_DONE: begin
            state     <= S_IDLE;
            ready     <= 1'b1;
            nrn_reset <= 1'b1;
          end
          default: begin
            state     <= S_IDLE;
            ready     <= 1'b1;
            nrn_reset <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
